fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_if.sv | 44 ++++
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    // Arbiter FSM states: waiting for a request, or serving one producer.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of a producer index; never narrower than one bit.
    function automatic int arb_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Width of the per-grant beat counter, wide enough to hold MAX_BURST.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshakes and FIFO write-port bundle shared by the arbiter
// and whatever drives it (producers plus the downstream FIFO).
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = arb_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          grant_valid;
    logic [IDX_W-1:0]              grant_id;

    // Environment side: producers present words, FIFO reports full.
    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  grant_valid,
        input  grant_id
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_wr_data,
        output grant_valid,
        output grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: returns the first set request at or above ptr,
// wrapping around past the top index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        int slot;
        slot  = 0;
        found = 1'b0;
        index = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = int'(ptr) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            if (!found && req[slot]) begin
                found = 1'b1;
                index = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one synchronous FIFO write port among
// NUM_REQ valid/ready producers. One producer is granted at a time for up
// to MAX_BURST beats; the FIFO write strobe and data are combinational
// from the granted producer, so there is no data latency.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int IDX_W = arb_idx_w(NUM_REQ);
    localparam int CNT_W = burst_cnt_w(MAX_BURST);

    localparam logic [0:0]       ST_IDLE   = IDLE;
    localparam logic [0:0]       ST_BURST  = BURST;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    logic [0:0]            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_id_q;
    logic [CNT_W-1:0]      beat_cnt;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      next_ptr;

    logic                  in_burst;
    logic                  gnt_valid;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  transfer;
    logic                  last_beat;
    logic [NUM_REQ-1:0]    ready_vec;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // The pointer wraps by compare-and-reset so non-power-of-two NUM_REQ
    // never lands on an index that has no producer behind it.
    assign next_ptr = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);

    assign in_burst  = (state == ST_BURST);
    assign transfer  = in_burst && gnt_valid && !bus.fifo_full;
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Select the granted producer's valid bit and data word.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDX_W'(i)) begin
                gnt_valid = bus.req_valid[i];
                gnt_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready goes only to the granted producer, and only while the FIFO has
    // room; it does not depend on valid, so a full FIFO always backpressures.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_burst && !bus.fifo_full && (grant_id_q == IDX_W'(i))) begin
                ready_vec[i] = 1'b1;
            end
        end
    end

    assign bus.req_ready    = ready_vec;
    assign bus.fifo_wr_en   = transfer;
    assign bus.fifo_wr_data = gnt_data;
    assign bus.grant_valid  = in_burst;
    assign bus.grant_id     = grant_id_q;

    // Grant FSM: arbitrate in IDLE, count beats in BURST, and release on the
    // last beat or as soon as the granted producer stops asserting valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id_q <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id_q <= pick_idx;
                        rr_ptr     <= next_ptr;
                        beat_cnt   <= '0;
                        state      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!gnt_valid) begin
                        beat_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (transfer) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a table of per-cycle vectors for the FSM
// corner cases, then scripted and random producer traffic into a 16-deep
// FIFO model with a per-producer scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NR-1:0]    tb_valid = '0;
    logic [NR*DW-1:0] tb_data  = '0;
    logic             tbl_mode = 1'b1;
    logic             tbl_full = 1'b0;
    logic             mdl_full = 1'b0;

    assign bus.req_valid = tb_valid;
    assign bus.req_data  = tb_data;
    assign bus.fifo_full = tbl_mode ? tbl_full : mdl_full;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // sampled DUT view of the current cycle
    logic [NR-1:0] s_rdy, s_xfer;
    logic          s_wr, s_gv, s_full;
    logic [1:0]    s_gid;
    logic [DW-1:0] s_data;

    // producers, scoreboard, FIFO model, write log
    logic [DW-1:0] p_data [NR];
    int            p_left [NR];
    logic [DW-1:0] exp_q  [NR][$];
    logic [DW-1:0] mdl_q  [$];
    int            wlog_cyc [$];
    logic [1:0]    wlog_gid [$];
    logic [DW-1:0] wlog_data[$];
    int            rd_pct   = 100;
    logic          rd_once  = 1'b0;
    logic          rand_mode = 1'b0;

    typedef struct packed {
        logic          rst;
        logic [NR-1:0] valid;
        logic          full;
        logic [NR-1:0] rdy;
        logic          wr;
        logic          gv;
        logic [1:0]    gid;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic present(input int i);
        exp_q[i].push_back(p_data[i]);
    endtask

    task automatic apply_drv();
        for (int i = 0; i < NR; i++) begin
            tb_valid[i]          = (p_left[i] > 0);
            tb_data[i*DW +: DW]  = p_data[i];
        end
    endtask

    // One clock: sample and score at negedge, then update FIFO model and
    // producers just after the rising edge.
    task automatic cycle();
        logic [DW-1:0] e;
        @(negedge clk);
        s_rdy  = bus.req_ready;
        s_wr   = bus.fifo_wr_en;
        s_data = bus.fifo_wr_data;
        s_gid  = bus.grant_id;
        s_gv   = bus.grant_valid;
        s_full = bus.fifo_full;
        s_xfer = tb_valid & s_rdy;
        chk("wr_en_vs_handshake", {63'd0, s_wr}, {63'd0, |s_xfer});
        if (s_rdy != '0) begin
            chk("ready_onehot_granted", {59'd0, s_gv, s_rdy}, {59'd0, 1'b1, 4'b0001 << s_gid});
        end
        if (s_wr) begin
            chk("no_write_when_full", {63'd0, s_full}, 64'd0);
            if (exp_q[s_gid].size() == 0) begin
                chk("sb_unexpected_word", {56'd0, s_data}, 64'hFFFF);
            end else begin
                e = exp_q[s_gid].pop_front();
                chk($sformatf("sb_order_p%0d", s_gid), {56'd0, s_data}, {56'd0, e});
            end
            wlog_cyc.push_back(cyc);
            wlog_gid.push_back(s_gid);
            wlog_data.push_back(s_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_wr) mdl_q.push_back(s_data);
        if ((rd_once || ($urandom_range(0, 99) < rd_pct)) && mdl_q.size() > 0) begin
            void'(mdl_q.pop_front());
        end
        rd_once  = 1'b0;
        mdl_full = (mdl_q.size() >= DEPTH);
        for (int i = 0; i < NR; i++) begin
            if (s_xfer[i]) begin
                p_left[i]--;
                p_data[i]++;
                if (p_left[i] > 0) present(i);
            end else if (rand_mode && p_left[i] == 0 && $urandom_range(0, 1) == 1) begin
                p_left[i] = 1;
                present(i);
            end
        end
        apply_drv();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) begin
            p_left[i] = 0;
            p_data[i] = '0;
            exp_q[i].delete();
        end
        apply_drv();
        mdl_q.delete();
        mdl_full = 1'b0;
        wlog_cyc.delete();
        wlog_gid.delete();
        wlog_data.delete();
        rand_mode = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_until_writes(input int n, input int budget);
        int b;
        b = budget;
        while (wlog_cyc.size() < n && b > 0) begin
            cycle();
            b--;
        end
        chk("write_count_timeout", 64'(wlog_cyc.size()), 64'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, valid, full | rdy, wr, gv, gid
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[3]  = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[5]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[6]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1};
        tbl[8]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
        tbl[9]  = '{1'b0, 4'b1010, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
        tbl[10] = '{1'b0, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3};
        tbl[11] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3};
        tbl[12] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[13] = '{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[14] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[15] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[16] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[17] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[18] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};

        // table phase: fixed data A0..A3, full driven directly
        tbl_mode = 1'b1;
        tb_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tb_valid = '0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 19; r++) begin
            rst      = tbl[r].rst;
            tb_valid = tbl[r].valid;
            tbl_full = tbl[r].full;
            @(negedge clk);
            if ({bus.req_ready, bus.fifo_wr_en, bus.grant_valid, bus.grant_id, bus.fifo_wr_data} !==
                {tbl[r].rdy, tbl[r].wr, tbl[r].gv, tbl[r].gid, 8'hA0 + 8'(tbl[r].gid)}) begin
                n_err++;
                $display("FAIL vec[%0d]: got rdy=%b wr=%b gv=%b gid=%0d data=%0h, expected rdy=%b wr=%b gv=%b gid=%0d data=%0h",
                         r, bus.req_ready, bus.fifo_wr_en, bus.grant_valid, bus.grant_id, bus.fifo_wr_data,
                         tbl[r].rdy, tbl[r].wr, tbl[r].gv, tbl[r].gid, 8'hA0 + 8'(tbl[r].gid));
            end
            n_vec++;
            @(posedge clk);
            #1;
        end
        tbl_mode = 1'b0;
        tbl_full = 1'b0;

        // single producer: 0x10..0x15, FIFO drained every cycle
        do_reset();
        rd_pct    = 100;
        p_data[1] = 8'h10;
        p_left[1] = 6;
        present(1);
        apply_drv();
        run_until_writes(6, 40);
        for (int k = 0; k < 6 && k < wlog_cyc.size(); k++) begin
            chk($sformatf("single_data%0d", k), {56'd0, wlog_data[k]}, 64'(8'h10 + k));
            chk($sformatf("single_gid%0d", k), {62'd0, wlog_gid[k]}, 64'd1);
            if (k > 0) begin
                chk($sformatf("single_gap%0d", k), 64'(wlog_cyc[k] - wlog_cyc[k-1]), (k == 4) ? 64'd2 : 64'd1);
            end
        end

        // all four contend from reset: grants 0,1,2,3,0 with four writes each
        do_reset();
        for (int i = 0; i < NR; i++) begin
            p_data[i] = 8'(i * 64);
            p_left[i] = 8;
            present(i);
        end
        apply_drv();
        run_until_writes(20, 200);
        for (int k = 0; k < 20 && k < wlog_gid.size(); k++) begin
            chk($sformatf("contend_gid%0d", k), {62'd0, wlog_gid[k]}, 64'((k / 4) % 4));
        end

        // full stall: 13 words already queued, producer 2 fills the FIFO on beat 2
        do_reset();
        rd_pct = 0;
        for (int k = 0; k < 13; k++) mdl_q.push_back(8'hEE);
        mdl_full  = 1'b0;
        p_data[2] = 8'h20;
        p_left[2] = 4;
        present(2);
        apply_drv();
        run_until_writes(3, 20);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("stall%0d", k), {56'd0, s_rdy, s_wr, s_gv, s_gid}, {56'd0, 4'b0000, 1'b0, 1'b1, 2'd2});
        end
        rd_once = 1'b1;
        cycle();
        chk("stall_before_read", {61'd0, s_wr, s_full, s_gv}, {61'd0, 1'b0, 1'b1, 1'b1});
        cycle();
        chk("stall_beat3", {55'd0, s_wr, s_data}, {55'd0, 1'b1, 8'h23});
        cycle();
        chk("stall_release", {63'd0, s_gv}, 64'd0);

        // random traffic with random draining
        do_reset();
        rd_pct    = 40;
        rand_mode = 1'b1;
        repeat (2000) cycle();
        rand_mode = 1'b0;
        rd_pct    = 100;
        begin
            int budget;
            int pend;
            budget = 400;
            pend   = 1;
            while (pend != 0 && budget > 0) begin
                cycle();
                budget--;
                pend = 0;
                for (int i = 0; i < NR; i++) pend += p_left[i];
            end
            chk("random_drain_timeout", 64'(pend), 64'd0);
        end
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("lost_words_p%0d", i), 64'(exp_q[i].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
